// File: rtl/m_phy_pkg.sv
// -----------------------------------------------------------------------------
// m_phy_pkg
// Shared definitions for the M-PHY lane serializer.
//   ser_state_e      : serializer FSM state (IDLE / SHIFT)
//   M_PHY_SYM_W      : default encoded symbol width (10b after 8b10b)
//   M_PHY_K28_5_RDN  : K28.5 (RD-) comma in transmit order, used as filler
// -----------------------------------------------------------------------------
package m_phy_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } ser_state_e;

    localparam int M_PHY_SYM_W = 10;

    localparam logic [M_PHY_SYM_W-1:0] M_PHY_K28_5_RDN = 10'h17C;

endpackage

// File: rtl/m_phy_sym_fifo.sv
// -----------------------------------------------------------------------------
// m_phy_sym_fifo
// Small synchronous symbol FIFO. Pointers carry one extra wrap bit, so full
// and empty fall out of a pointer compare and the occupancy is their
// difference. The head is read combinationally so the serializer can load
// it on the same edge that pops it. A write is never visible at the head
// before the following edge, which means there is no push-to-pop bypass.
//
// Ports:
//   clk, reset_n  : clock, asynchronous active-low reset
//   flush         : synchronous clear of both pointers (wins over push/pop)
//   push, wdata   : write request and data (ignored when full)
//   pop           : remove the head (ignored when empty)
//   rdata         : current head symbol
//   full, empty   : occupancy flags
//   level         : number of stored symbols
// -----------------------------------------------------------------------------
module m_phy_sym_fifo
    import m_phy_pkg::*;
#(
    parameter int W     = M_PHY_SYM_W,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       flush,
    input  logic                       push,
    input  logic [W-1:0]               wdata,
    input  logic                       pop,
    output logic [W-1:0]               rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH+1);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr_reg;
    logic [AW:0]  rd_ptr_reg;
    logic         wr_en;
    logic         rd_en;

    assign wr_en = push && !full && !flush;
    assign rd_en = pop && !empty && !flush;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (rd_en) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
        end
    end

    // Storage carries no reset: pointer state alone defines validity.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_reg[AW-1:0]] <= wdata;
        end
    end

    assign rdata = mem[rd_ptr_reg[AW-1:0]];
    assign empty = (wr_ptr_reg == rd_ptr_reg);
    assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    // With DEPTH a power of two the pointer difference is exactly LW bits.
    assign level = LW'(wr_ptr_reg - rd_ptr_reg);

endmodule

// File: rtl/m_phy_lane_ser.sv
// -----------------------------------------------------------------------------
// m_phy_lane_ser
// M-PHY lane serializer: buffers encoded symbols in a small FIFO and emits
// them OUT_W bits per enabled beat, MSB-first or LSB-first per symbol.
//
// Parameters:
//   SYM_W : symbol width (default 10)
//   OUT_W : bits per beat, must divide SYM_W
//   DEPTH : FIFO depth, power of two >= 2
//
// Ports:
//   clk, reset_n        : clock, asynchronous active-low reset
//   enable              : beat strobe, one slice advances per enabled cycle
//   flush               : synchronous clear of FIFO and shifter
//   lsb_first           : bit order, sampled as each symbol is loaded
//   in_valid/in_data    : symbol input; in_ready = !full && !flush
//   fill_sym            : filler symbol (used only with the fill option)
//   dout, dout_valid    : current output slice / shifter active
//   sym_start           : dout is the first slice of a symbol
//   underflow           : one-cycle pulse after a starved symbol boundary
//   level               : FIFO occupancy
//
// Build option:
//   M_PHY_SER_FILL_EN   : when defined, a starved boundary loads fill_sym and
//                         the shifter stays active; otherwise it drops to IDLE.
// -----------------------------------------------------------------------------
module m_phy_lane_ser
    import m_phy_pkg::*;
#(
    parameter int SYM_W = M_PHY_SYM_W,
    parameter int OUT_W = 1,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       enable,
    input  logic                       flush,
    input  logic                       lsb_first,
    input  logic                       in_valid,
    input  logic [SYM_W-1:0]           in_data,
    output logic                       in_ready,
    input  logic [SYM_W-1:0]           fill_sym,
    output logic [OUT_W-1:0]           dout,
    output logic                       dout_valid,
    output logic                       sym_start,
    output logic                       underflow,
    output logic [$clog2(DEPTH+1)-1:0] level
);

    localparam int BEATS = SYM_W / OUT_W;
    localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

    ser_state_e   state_reg, state_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic [SYM_W-1:0] shreg_reg, shreg_next;
    logic         underflow_reg, underflow_next;

    logic [SYM_W-1:0] fifo_rdata;
    logic [SYM_W-1:0] head_rev;
    logic         fifo_full;
    logic         fifo_empty;
    logic         push;
    logic         pop;

    // ---------------------------------------------------------------------
    // Symbol buffer
    // ---------------------------------------------------------------------
    assign in_ready = !fifo_full && !flush;
    assign push     = in_valid && in_ready;

    m_phy_sym_fifo #(
        .W     (SYM_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .flush   (flush),
        .push    (push),
        .wdata   (in_data),
        .pop     (pop),
        .rdata   (fifo_rdata),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (level)
    );

    // The shifter always emits from its MSB end; LSB-first order is obtained
    // by loading the symbol bit-reversed.
    for (genvar gi = 0; gi < SYM_W; gi++) begin : g_head_rev
        assign head_rev[gi] = fifo_rdata[SYM_W-1-gi];
    end

`ifdef M_PHY_SER_FILL_EN
    logic [SYM_W-1:0] fill_rev;

    // The filler follows the same bit-order rule as a real symbol.
    for (genvar gi = 0; gi < SYM_W; gi++) begin : g_fill_rev
        assign fill_rev[gi] = fill_sym[SYM_W-1-gi];
    end
`else
    logic unused_fill;
    assign unused_fill = ^fill_sym;
`endif

    // ---------------------------------------------------------------------
    // Serializer FSM: state register
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            shreg_reg     <= '0;
            underflow_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            shreg_reg     <= shreg_next;
            underflow_reg <= underflow_next;
        end
    end

    // ---------------------------------------------------------------------
    // Serializer FSM: next state, pop request
    // ---------------------------------------------------------------------
    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        shreg_next     = shreg_reg;
        underflow_next = 1'b0;
        pop            = 1'b0;

        if (flush) begin
            state_next = IDLE;
            cnt_next   = '0;
            shreg_next = '0;
        end else if (enable) begin
            case (state_reg)
                IDLE: begin
                    if (!fifo_empty) begin
                        pop        = 1'b1;
                        shreg_next = lsb_first ? head_rev : fifo_rdata;
                        cnt_next   = '0;
                        state_next = SHIFT;
                    end
                end
                SHIFT: begin
                    if (cnt_reg != LAST_BEAT) begin
                        shreg_next = shreg_reg << OUT_W;
                        cnt_next   = cnt_reg + CW'(1);
                    end else if (!fifo_empty) begin
                        // Seamless hand-over to the next buffered symbol.
                        pop        = 1'b1;
                        shreg_next = lsb_first ? head_rev : fifo_rdata;
                        cnt_next   = '0;
                    end else begin
                        underflow_next = 1'b1;
                        cnt_next       = '0;
`ifdef M_PHY_SER_FILL_EN
                        shreg_next     = lsb_first ? fill_rev : fill_sym;
`else
                        shreg_next     = '0;
                        state_next     = IDLE;
`endif
                    end
                end
                default: begin
                    state_next = IDLE;
                    cnt_next   = '0;
                    shreg_next = '0;
                end
            endcase
        end
    end

    // ---------------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------------
    assign dout_valid = (state_reg == SHIFT);
    assign dout       = dout_valid ? shreg_reg[SYM_W-1 -: OUT_W] : '0;
    assign sym_start  = dout_valid && (cnt_reg == '0);
    assign underflow  = underflow_reg;

endmodule

// File: tb/tb_m_phy_lane_ser.sv
// -----------------------------------------------------------------------------
// tb_m_phy_lane_ser
// Two serializers (OUT_W=1 and OUT_W=2, SYM_W=10, DEPTH=4) driven by the same
// stimulus. Directed table sequences, hand-written corner sequences, then
// random traffic, all compared against a queue/arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_m_phy_lane_ser;

    localparam int SYM_W = 10;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        enable;
    logic        flush;
    logic        lsb_first;
    logic        in_valid;
    logic [9:0]  in_data;
    logic [9:0]  fill_sym;

    logic        ready0, ready1;
    logic [0:0]  dout0;
    logic [1:0]  dout1;
    logic        dv0, dv1, ss0, ss1, uf0, uf1;
    logic [2:0]  lvl0, lvl1;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    m_phy_lane_ser #(.SYM_W(SYM_W), .OUT_W(1), .DEPTH(DEPTH)) dut0 (
        .clk(clk), .reset_n(reset_n), .enable(enable), .flush(flush),
        .lsb_first(lsb_first), .in_valid(in_valid), .in_data(in_data),
        .in_ready(ready0), .fill_sym(fill_sym), .dout(dout0),
        .dout_valid(dv0), .sym_start(ss0), .underflow(uf0), .level(lvl0)
    );

    m_phy_lane_ser #(.SYM_W(SYM_W), .OUT_W(2), .DEPTH(DEPTH)) dut1 (
        .clk(clk), .reset_n(reset_n), .enable(enable), .flush(flush),
        .lsb_first(lsb_first), .in_valid(in_valid), .in_data(in_data),
        .in_ready(ready1), .fill_sym(fill_sym), .dout(dout1),
        .dout_valid(dv1), .sym_start(ss1), .underflow(uf1), .level(lvl1)
    );

    // ---------------------------------------------------------------------
    // Reference model: per lane a plain array FIFO, the current symbol as a
    // transmit-ordered word and the number of bits already sent.
    // ---------------------------------------------------------------------
    int m_fifo [2][DEPTH];
    int m_cnt  [2];
    int m_cur  [2];
    int m_pos  [2];
    bit m_act  [2];
    bit m_uf   [2];

    function automatic int rev10(input int w);
        int r = 0;
        for (int i = 0; i < 10; i++) begin
            if (((w >> i) & 1) != 0) r |= (1 << (9 - i));
        end
        return r;
    endfunction

    task automatic model_reset();
        for (int l = 0; l < 2; l++) begin
            m_cnt[l] = 0; m_cur[l] = 0; m_pos[l] = 0; m_act[l] = 0; m_uf[l] = 0;
        end
    endtask

    task automatic model_load(input int l, input int w);
        m_cur[l] = lsb_first ? rev10(w) : w;
        m_pos[l] = 0;
        m_act[l] = 1'b1;
    endtask

    task automatic model_step();
        for (int l = 0; l < 2; l++) begin
            int ow;
            int pre;
            bit popped;
            ow = l + 1;
            pre = m_cnt[l];
            popped = 1'b0;
            if (!reset_n) begin
                m_cnt[l] = 0; m_pos[l] = 0; m_act[l] = 0; m_uf[l] = 0;
            end else if (flush) begin
                m_cnt[l] = 0; m_pos[l] = 0; m_act[l] = 0; m_uf[l] = 0;
            end else begin
                m_uf[l] = 1'b0;
                if (enable) begin
                    if (m_act[l]) begin
                        if (m_pos[l] + ow < SYM_W) begin
                            m_pos[l] += ow;
                        end else if (pre > 0) begin
                            model_load(l, m_fifo[l][0]);
                            popped = 1'b1;
                        end else begin
                            m_uf[l] = 1'b1;
`ifdef M_PHY_SER_FILL_EN
                            model_load(l, int'(fill_sym));
`else
                            m_act[l] = 1'b0;
                            m_pos[l] = 0;
`endif
                        end
                    end else if (pre > 0) begin
                        model_load(l, m_fifo[l][0]);
                        popped = 1'b1;
                    end
                end
                if (popped) begin
                    for (int i = 0; i < DEPTH - 1; i++) m_fifo[l][i] = m_fifo[l][i+1];
                    m_cnt[l]--;
                end
                if (in_valid && pre < DEPTH) begin
                    m_fifo[l][m_cnt[l]] = int'(in_data);
                    m_cnt[l]++;
                end
            end
        end
    endtask

    function automatic int exp_dout(input int l);
        int ow = l + 1;
        if (!m_act[l]) return 0;
        return (m_cur[l] >> (SYM_W - m_pos[l] - ow)) & ((1 << ow) - 1);
    endfunction

    // ---------------------------------------------------------------------
    // Checking
    // ---------------------------------------------------------------------
    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("l0.dout",      32'(dout0), 32'(exp_dout(0)));
        chk("l0.dout_valid", 32'(dv0),  32'(m_act[0]));
        chk("l0.sym_start", 32'(ss0),   32'(m_act[0] && m_pos[0] == 0));
        chk("l0.underflow", 32'(uf0),   32'(m_uf[0]));
        chk("l0.level",     32'(lvl0),  32'(m_cnt[0]));
        chk("l0.in_ready",  32'(ready0), 32'(m_cnt[0] < DEPTH && !flush));
        chk("l1.dout",      32'(dout1), 32'(exp_dout(1)));
        chk("l1.dout_valid", 32'(dv1),  32'(m_act[1]));
        chk("l1.sym_start", 32'(ss1),   32'(m_act[1] && m_pos[1] == 0));
        chk("l1.underflow", 32'(uf1),   32'(m_uf[1]));
        chk("l1.level",     32'(lvl1),  32'(m_cnt[1]));
        chk("l1.in_ready",  32'(ready1), 32'(m_cnt[1] < DEPTH && !flush));
    endtask

    // Drive inputs (called #1 after a posedge) and check at the falling edge.
    task automatic apply(input logic en, input logic fl, input logic lsb,
                         input logic v, input logic [9:0] d);
        enable = en; flush = fl; lsb_first = lsb; in_valid = v; in_data = d;
        @(negedge clk);
        check_all();
    endtask

    task automatic advance();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic cyc(input logic en, input logic fl, input logic lsb,
                       input logic v, input logic [9:0] d);
        apply(en, fl, lsb, v, d);
        advance();
    endtask

    // ---------------------------------------------------------------------
    // Directed table
    // ---------------------------------------------------------------------
    typedef struct {
        logic       v;
        logic [9:0] d;
        logic       lsb;
        logic       en;
        logic       dv0;
        logic       o0;
        logic       ss0;
        logic       chk1;
        logic       dv1;
        logic [1:0] o1;
        logic       ss1;
    } vec_t;

    vec_t tbl[$];
    int   seq_start[4];

    // s0/s1: symbols pushed on cycles 0 and 1; st0: lane0 bit stream;
    // st1: lane1 slice stream (2 bits per beat, first beat in bits 19:18).
    task automatic add_seq(input logic lsb, input logic [9:0] s0, input logic two,
                           input logic [9:0] s1, input logic [9:0] st0,
                           input logic [19:0] st1, input int n1);
        vec_t r;
        r = '{v:1'b1, d:s0, lsb:lsb, en:1'b1, dv0:1'b0, o0:1'b0, ss0:1'b0,
              chk1:1'b1, dv1:1'b0, o1:2'b00, ss1:1'b0};
        tbl.push_back(r);
        r.v = two; r.d = s1;
        tbl.push_back(r);
        for (int k = 0; k < 10; k++) begin
            r.v    = 1'b0;
            r.d    = 10'h000;
            r.dv0  = 1'b1;
            r.o0   = st0[9-k];
            r.ss0  = (k == 0);
            r.chk1 = (k < n1);
            r.dv1  = 1'b1;
            r.o1   = st1[19-2*k -: 2];
            r.ss1  = (k == 0) || (k == 5);
            tbl.push_back(r);
        end
    endtask

    task automatic run_seq(input int s);
        for (int i = seq_start[s]; i < seq_start[s+1]; i++) begin
            apply(tbl[i].en, 1'b0, tbl[i].lsb, tbl[i].v, tbl[i].d);
            chk($sformatf("tbl%0d[%0d].dv0", s, i - seq_start[s]), 32'(dv0), 32'(tbl[i].dv0));
            chk($sformatf("tbl%0d[%0d].dout0", s, i - seq_start[s]), 32'(dout0), 32'(tbl[i].o0));
            chk($sformatf("tbl%0d[%0d].ss0", s, i - seq_start[s]), 32'(ss0), 32'(tbl[i].ss0));
            if (tbl[i].chk1) begin
                chk($sformatf("tbl%0d[%0d].dv1", s, i - seq_start[s]), 32'(dv1), 32'(tbl[i].dv1));
                chk($sformatf("tbl%0d[%0d].dout1", s, i - seq_start[s]), 32'(dout1), 32'(tbl[i].o1));
                chk($sformatf("tbl%0d[%0d].ss1", s, i - seq_start[s]), 32'(ss1), 32'(tbl[i].ss1));
            end
            advance();
        end
    endtask

    // ---------------------------------------------------------------------
    // Test sequence
    // ---------------------------------------------------------------------
    initial begin
        // MSB-first 0x2A5
        seq_start[0] = tbl.size();
        add_seq(1'b0, 10'h2A5, 1'b0, 10'h000, 10'b1010100101,
                20'b1010100101_0000000000, 5);
        // LSB-first 0x2A5
        seq_start[1] = tbl.size();
        add_seq(1'b1, 10'h2A5, 1'b0, 10'h000, 10'b1010010101,
                20'b1010010101_0000000000, 5);
        // 0x2A5 then 0x155 back to back
        seq_start[2] = tbl.size();
        add_seq(1'b0, 10'h2A5, 1'b1, 10'h155, 10'b1010100101,
                20'b10101001010101010101, 10);
        seq_start[3] = tbl.size();

        reset_n = 1'b0; enable = 1'b0; flush = 1'b0; lsb_first = 1'b0;
        in_valid = 1'b0; in_data = '0; fill_sym = 10'h17C;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all();
        chk("reset.in_ready", 32'(ready0), 32'd1);
        reset_n = 1'b1;

        // MSB-first single symbol, then starvation
        run_seq(0);
        apply(1'b1, 1'b0, 1'b0, 1'b0, 10'h000);
        chk("uf.pulse", 32'(uf0), 32'd1);
`ifdef M_PHY_SER_FILL_EN
        chk("fill.dv", 32'(dv0), 32'd1);
        chk("fill.bit0", 32'(dout0), 32'd0);
        chk("fill.ss", 32'(ss0), 32'd1);
`else
        chk("idle.dv", 32'(dv0), 32'd0);
        chk("idle.dout", 32'(dout0), 32'd0);
`endif
        advance();
        apply(1'b1, 1'b0, 1'b0, 1'b0, 10'h000);
        chk("uf.once", 32'(uf0), 32'd0);
`ifdef M_PHY_SER_FILL_EN
        chk("fill.bit1", 32'(dout0), 32'd1);
`else
        chk("idle.dv2", 32'(dv0), 32'd0);
`endif
        advance();
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 10'h000);

        run_seq(1);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 10'h000);

        run_seq(2);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 10'h000);

        // Fill the FIFO with the beat strobe off
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b0, 1'b1, 10'(10'h101 + i));
        apply(1'b0, 1'b0, 1'b0, 1'b1, 10'h3FF);
        chk("full.level", 32'(lvl0), 32'd4);
        chk("full.in_ready", 32'(ready0), 32'd0);
        advance();
        apply(1'b0, 1'b0, 1'b0, 1'b0, 10'h000);
        chk("full.no_5th", 32'(lvl0), 32'd4);
        advance();
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 10'h000);
        apply(1'b1, 1'b0, 1'b0, 1'b0, 10'h000);
        chk("pop.in_ready", 32'(ready0), 32'd1);
        chk("pop.level", 32'(lvl0), 32'd3);
        advance();
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 10'h000);

        // Asynchronous reset at beat 4 with a symbol still buffered
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 10'h2A5);
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 10'h0F0);
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0, 10'h000);
        apply(1'b1, 1'b0, 1'b0, 1'b0, 10'h000);
        chk("rst.beat4.ss", 32'(ss0), 32'd0);
        #2 reset_n = 1'b0;
        #1;
        model_reset();
        chk("rst.dout0", 32'(dout0), 32'd0);
        chk("rst.dv0", 32'(dv0), 32'd0);
        chk("rst.ss0", 32'(ss0), 32'd0);
        chk("rst.uf0", 32'(uf0), 32'd0);
        chk("rst.lvl0", 32'(lvl0), 32'd0);
        chk("rst.rdy0", 32'(ready0), 32'd1);
        chk("rst.dv1", 32'(dv1), 32'd0);
        chk("rst.lvl1", 32'(lvl1), 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0, 10'h000);

        // Write coincident with flush is dropped
        apply(1'b0, 1'b1, 1'b0, 1'b1, 10'h111);
        chk("flush.in_ready", 32'(ready0), 32'd0);
        advance();
        apply(1'b0, 1'b0, 1'b0, 1'b0, 10'h000);
        chk("flush.level", 32'(lvl0), 32'd0);
        advance();

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) fill_sym = 10'($urandom);
            cyc($urandom_range(0, 9) < 7, $urandom_range(0, 99) < 3,
                1'($urandom), $urandom_range(0, 1) == 1, 10'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/m_phy_lane_ser.md
# m_phy_lane_ser

Parametrised M-PHY lane serializer. It accepts encoded symbols (10b by default) through a ready/valid handshake and buffers them in a small FIFO. It shifts them out `OUT_W` bits per enabled beat, MSB- or LSB-first per symbol. It sits between the lane 8b10b encoder and the analog TX interface and supersedes the fixed 10-bit load/shift serializer, adding buffering, a multi-bit output, bit-order selection and underflow handling.

## Interface
- `SYM_W`, default 10: symbol width in bits.
- `OUT_W`, default 1: bits emitted per enabled beat. Must divide `SYM_W` exactly.
- `DEPTH`, default 4: FIFO depth in symbols. Must be a power of two, ≥2.
- `clk` input 1: the single clock.
- `reset_n` input 1: asynchronous, active-low reset.
- `enable` input 1: beat strobe; one `OUT_W` slice advances per cycle with `enable`=1.
- `flush` input 1: synchronous clear of the FIFO and shifter.
- `lsb_first` input 1: bit order, sampled when each symbol is loaded.
- `in_valid` input 1: symbol present.
- `in_data` input `SYM_W`: symbol.
- `in_ready` output 1: equals `!full && !flush`.
- `fill_sym` input `SYM_W`: filler symbol; used only when the fill macro is defined.
- `dout` output `OUT_W`: current output slice.
- `dout_valid` output 1: shifter is in SHIFT.
- `sym_start` output 1: `dout` currently shows the first slice of a symbol.
- `underflow` output 1: one-cycle pulse.
- `level` output `$clog2(DEPTH+1)`: FIFO occupancy.

## Operation
- `BEATS` = `SYM_W/OUT_W`. The beat counter runs 0..`BEATS`-1.
- A push happens when `in_valid && in_ready`. There is no push-to-pop bypass. A pop when full frees a slot on the next cycle, not the same one.
- **IDLE state.**
  - `dout`=0, `dout_valid`=0.
  - If `enable` and the FIFO is non-empty: pop the head into the shift register (bit-reversed if `lsb_first`), clear the counter, go to SHIFT.
- **SHIFT state.**
  - `dout` is the top `OUT_W` bits of the shift register.
  - With `enable` and counter < `BEATS`-1: shift left by `OUT_W`, counter +1.
  - With `enable` and counter = `BEATS`-1 (symbol boundary):
    - FIFO non-empty: pop and load the next symbol seamlessly, counter→0.
    - FIFO empty: behaviour is set by Configuration.
  - With `enable`=0: all state holds.
- `sym_start` = SHIFT && counter==0.
- **Flush.**
  - Empties the FIFO, clears the shifter, forces IDLE on the next edge.
  - Takes priority over push, pop and `enable`.
  - A write in the same cycle as `flush` is dropped, since `in_ready` is 0.
- **Reset.**
  - Asynchronous; any state, including mid-symbol.
  - FIFO empty, state IDLE, counter 0.
  - Outputs: `dout`=0, `dout_valid`=0, `sym_start`=0, `underflow`=0, `level`=0.
  - `in_ready`=1, since the FIFO is empty.

## Timing
- Latency: a symbol pushed at edge N into an empty, idle block with `enable` high pops at edge N+1. Its first slice is on `dout` during cycle N+1→N+2. A symbol is never popped on the same edge it is pushed.
- Back-to-back symbols produce no gap beats while the FIFO is non-empty.
- `level` updates on the edge after a push or pop. A simultaneous push and pop leaves it unchanged.
- `underflow` is registered and asserts for one cycle, on the cycle after the boundary edge.

## Configuration
- `M_PHY_SER_FILL_EN` defined:
  - An empty FIFO at a symbol boundary loads `fill_sym`, stays in SHIFT and pulses `underflow`.
  - Leaving SHIFT then requires `flush` or reset.
- `M_PHY_SER_FILL_EN` undefined:
  - An empty FIFO at a symbol boundary moves to IDLE and pulses `underflow`.
  - `fill_sym` is ignored.

## Structure
- Package `m_phy_pkg` holds:
  - the state enum `ser_state_e` {IDLE, SHIFT};
  - the default symbol width constant `M_PHY_SYM_W`=10;
  - the K28.5 RD− constant used by benches as the filler.
- One sub-module, `m_phy_sym_fifo`:
  - parametrised on width and depth;
  - full and empty flags derived from pointers with one extra wrap bit;
  - `level` output.
- The serializer FSM, counter and shifter live in the top level.

## Test plan
- `SYM_W`=10, `OUT_W`=1, `lsb_first`=0, push `10'h2A5`, `enable` held high → `dout` = 1,0,1,0,1,0,0,1,0,1, with `sym_start` on the first beat only.
- Same with `lsb_first`=1 → `dout` = 1,0,1,0,0,1,0,1,0,1.
- `OUT_W`=2, push `10'h2A5`, then `10'h155` → 10 consecutive valid beats: `2'b10,2'b10,2'b10,2'b01,2'b01,2'b01,2'b01,2'b01,2'b01,2'b01`, with `sym_start` on beats 0 and 5.
- Four pushes with `enable`=0:
  - `level`=4 and `in_ready`=0;
  - a fifth `in_valid` is not accepted;
  - after `enable` rises and one pop, `in_ready` returns to 1 on the next cycle.
- Single symbol, then FIFO runs empty:
  - without the macro → `underflow` pulses once, IDLE, `dout`=0;
  - with the macro → `fill_sym`=`10'h17C` shifts out next, plus an `underflow` pulse.
- `reset_n` asserted at beat 4 of a symbol → outputs reach their reset values immediately and the FIFO is empty.
- `flush` together with `in_valid` → the symbol is dropped and `level`=0 next cycle.
